lsu_mem_master: RTL and testbench
=================================

Name: lsu_mem_master

Overview:
- Initiator-side load/store unit for the multicycle RISC-V CPU; drives the data RAM port (we, addr, wData, ramControl) and consumes rData.
- Accepts one CPU memory request at a time over a valid/ready handshake.
- Aligned accesses complete in one RAM beat.
- Misaligned half/word accesses are split into sequential byte beats. Load bytes are assembled and extended; store bytes are written one at a time.
- Returns a one-cycle response pulse with load data or an error flag.

Parameters:
- MEM_DEPTH, 256, RAM depth in 32-bit words; valid byte range is 0 .. 4*MEM_DEPTH-1.
- SPLIT_EN, 1, 1 = split misaligned accesses into byte beats; 0 = misaligned access returns error with no RAM access.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; request accepted on clk edge when req_valid && req_ready
- req_we  in  1  1 = store, 0 = load
- req_size  in  3  size code: 000 word, 001 byte signed, 010 half signed, 101 byte unsigned, 110 half unsigned
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  valid with resp_valid; illegal size, misaligned with SPLIT_EN=0, or out of range
- resp_rdata  out  32  load result, valid with resp_valid; 0 for stores and errors
- ram_we  out  1  RAM write enable
- ram_addr  out  32  RAM byte address
- ram_wData  out  32  RAM write data
- ram_ramControl  out  3  RAM size code
- ram_rData  in  32  RAM combinational read data

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high.
- Reset values:
  - State IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0.
  - ram_we=0, ram_addr=0, ram_wData=0, ram_ramControl=000.
  - ram_we is decoded from state, so it drops immediately on reset assertion.
- FSM states: IDLE, SINGLE, SPLIT, RESP.
- Accept in IDLE:
  - Latch we, size, addr, wdata.
  - Clear the assembly register and the beat counter k.
- Error classification at accept:
  - Illegal size: 011, 100, 111 for loads; any size other than 000/001/010 for stores.
  - Out of range: addr + bytes - 1 >= 4*MEM_DEPTH, evaluated with a 33-bit sum; a wrap past 2^32 is out of range.
  - Misaligned with SPLIT_EN=0.
  - Any error goes directly to RESP with resp_err=1. No RAM beat is issued.
- Aligned access (byte always; half with addr[0]=0; word with addr[1:0]=0): go to SINGLE.
  - SINGLE drives ram_addr=addr, ram_ramControl=size, ram_we=we, ram_wData=wdata for exactly one cycle.
  - A load captures ram_rData at the end of SINGLE, then goes to RESP.
- Misaligned access (half, or word with addr[1:0]!=0): go to SPLIT with N=2 (half) or N=4 (word).
  - Beat k (0..N-1) drives ram_addr=addr+k, one cycle per beat.
  - Load beat: ram_ramControl=101; capture ram_rData[7:0] into assembly[8k+7:8k].
  - Store beat: ram_we=1, ram_ramControl=001, ram_wData={24'b0, wdata[8k+7:8k]}.
  - After beat N-1, go to RESP.
- RESP: resp_valid=1 for one cycle, then return to IDLE.
  - resp_rdata is registered.
  - Half signed (010): sign-extend from assembly[15]. Half unsigned (110): zero-extend. Word: no extension.
- Latency from the accept edge to resp_valid high:
  - Aligned: 2 cycles.
  - Split half: 3 cycles.
  - Split word: 5 cycles.
  - Error: 1 cycle.
- req_ready=0 in SINGLE, SPLIT and RESP. req_valid in those states is ignored and not queued.
- Outside SINGLE/SPLIT: ram_we=0, ram_wData=0, ram_ramControl=000, ram_addr holds the latched address.
- Reset mid-SPLIT: return to IDLE, no response. Store bytes already written remain in RAM.

Decomposition:
- Package mem_pkg:
  - Size-code localparams: SZ_W, SZ_B, SZ_H, SZ_BU, SZ_HU.
  - State enum.
  - Helper function returning the byte count per size code.
- Sub-module lsu_extend: combinational sign/zero extension of the 32-bit assembly by size code. Shared with the aligned path so extension is done in one place.

Test Plan:
- Store word 0xDEADBEEF to 0x10, then load word 0x10 -> resp_valid 2 cycles after each accept; rdata 0xDEADBEEF, err 0; one ram_we pulse.
- Load size 001 at 0x13 after that store -> rdata 0xFFFFFFDE. Load size 101 at 0x13 -> 0x000000DE.
- Store word 0x11223344 to 0x21 -> exactly 4 ram_we beats at 0x21..0x24 with data 0x44, 0x33, 0x22, 0x11. Load word 0x21 -> 0x11223344 with resp_valid 5 cycles after accept.
- Load size 010 at 0x23 where the bytes at 0x23/0x24 are 0x80/0x90 -> rdata 0xFFFF9080. Same load with size 110 -> 0x00009080.
- Error cases, each giving resp_err=1, rdata 0, no ram_we, resp 1 cycle after accept:
  - Size 011 load.
  - Store with size 101.
  - Word access at 0x3FE with MEM_DEPTH=256.
  - SPLIT_EN=0 word access at 0x2.
- Misaligned word store at 0x31, reset asserted during beat 1 -> outputs return to reset values immediately; byte 0x31 written, bytes 0x32..0x34 unchanged; no resp_valid; next request accepted normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the load/store unit:
// size codes, FSM states and byte-count helper.
package mem_pkg;

    localparam logic [2:0] SZ_W  = 3'b000;
    localparam logic [2:0] SZ_B  = 3'b001;
    localparam logic [2:0] SZ_H  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b101;
    localparam logic [2:0] SZ_HU = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SINGLE,
        ST_SPLIT,
        ST_RESP
    } state_t;

    // Bytes touched by a size code; 0 marks an unusable code
    function automatic logic [2:0] size_bytes(input logic [2:0] sz);
        logic [2:0] n;
        case (sz[1:0])
            2'b00:   n = 3'd4;
            2'b01:   n = 3'd1;
            2'b10:   n = 3'd2;
            default: n = 3'd0;
        endcase
        return n;
    endfunction

    // Stores have no unsigned variants
    function automatic logic size_legal(
        input logic       we,
        input logic [2:0] sz
    );
        logic ok;
        if (we)
            ok = (sz == SZ_W) || (sz == SZ_B) || (sz == SZ_H);
        else
            ok = (sz == SZ_W) || (sz == SZ_B) || (sz == SZ_H) ||
                 (sz == SZ_BU) || (sz == SZ_HU);
        return ok;
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// Sign/zero extension of load data by size code.
// Used for both aligned and byte-assembled loads.
module lsu_extend
    import mem_pkg::*;
(
    input  logic [31:0] i_data,
    input  logic [2:0]  i_size,
    output logic [31:0] o_data
);

    // Pick extension from the size code
    always_comb begin
        o_data = i_data;
        case (i_size)
            SZ_B:    o_data = {{24{i_data[7]}}, i_data[7:0]};
            SZ_BU:   o_data = {24'b0, i_data[7:0]};
            SZ_H:    o_data = {{16{i_data[15]}}, i_data[15:0]};
            SZ_HU:   o_data = {16'b0, i_data[15:0]};
            default: o_data = i_data;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store unit driving the data RAM port.
// Misaligned accesses are split into byte beats.
module lsu_mem_master
    import mem_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter bit SPLIT_EN  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wData,
    output logic [2:0]  ram_ramControl,
    input  logic [31:0] ram_rData
);

    localparam logic [32:0] LIMIT = 33'(4 * MEM_DEPTH);

    state_t      r_state;
    state_t      w_next;
    logic        r_we;
    logic [2:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_asm;
    logic [1:0]  r_k;
    logic        r_err;
    logic [31:0] r_rdata;

    logic        w_accept;
    logic [2:0]  w_bytes;
    logic [32:0] w_end;
    logic        w_oor;
    logic        w_mis;
    logic        w_err;
    logic [1:0]  w_last_k;
    logic        w_beat_last;
    logic [31:0] w_asm_next;
    logic [31:0] w_ext;
    logic [7:0]  w_wbyte;

    assign w_accept = req_valid && (r_state == ST_IDLE);
    assign w_bytes  = size_bytes(req_size);
    // 33-bit sum so a wrap past 2^32 reads as out of range
    assign w_end    = {1'b0, req_addr} + {30'b0, w_bytes} - 33'd1;
    assign w_oor    = (w_end >= LIMIT);
    assign w_mis    = ((req_size[1:0] == 2'b10) && req_addr[0]) ||
                      ((req_size == SZ_W) && (req_addr[1:0] != 2'b00));
    assign w_err    = !size_legal(req_we, req_size) || w_oor ||
                      (w_mis && !SPLIT_EN);

    assign w_last_k    = (r_size[1:0] == 2'b00) ? 2'd3 : 2'd1;
    assign w_beat_last = (r_k == w_last_k);
    assign w_wbyte     = r_wdata[{r_k, 3'b000} +: 8];

    // Next assembly value: whole word on a single beat, one byte per split beat
    always_comb begin
        w_asm_next = r_asm;
        if (r_state == ST_SINGLE)
            w_asm_next = ram_rData;
        else if (r_state == ST_SPLIT)
            w_asm_next[{r_k, 3'b000} +: 8] = ram_rData[7:0];
    end

    lsu_extend u_ext (
        .i_data (w_asm_next),
        .i_size (r_size),
        .o_data (w_ext)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_err)
                        w_next = ST_RESP;
                    else if (w_mis)
                        w_next = ST_SPLIT;
                    else
                        w_next = ST_SINGLE;
                end
            end
            ST_SINGLE: w_next = ST_RESP;
            ST_SPLIT: begin
                if (w_beat_last)
                    w_next = ST_RESP;
            end
            ST_RESP:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Output decode from state and latched request
    always_comb begin
        req_ready      = 1'b0;
        resp_valid     = 1'b0;
        resp_err       = 1'b0;
        resp_rdata     = 32'd0;
        ram_we         = 1'b0;
        ram_addr       = r_addr;
        ram_wData      = 32'd0;
        ram_ramControl = 3'b000;
        unique case (r_state)
            ST_IDLE: req_ready = 1'b1;
            ST_SINGLE: begin
                ram_we         = r_we;
                ram_wData      = r_wdata;
                ram_ramControl = r_size;
            end
            ST_SPLIT: begin
                ram_addr       = r_addr + {30'b0, r_k};
                ram_we         = r_we;
                ram_ramControl = r_we ? SZ_B : SZ_BU;
                ram_wData      = r_we ? {24'b0, w_wbyte} : 32'd0;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_err   = r_err;
                resp_rdata = r_rdata;
            end
            default: req_ready = 1'b0;
        endcase
    end

    // Request latch, beat counter and load assembly
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we    <= 1'b0;
            r_size  <= 3'b000;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_asm   <= 32'd0;
            r_k     <= 2'd0;
            r_err   <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_we    <= req_we;
                        r_size  <= req_size;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_asm   <= 32'd0;
                        r_k     <= 2'd0;
                        r_err   <= w_err;
                        r_rdata <= 32'd0;
                    end
                end
                ST_SINGLE: begin
                    r_asm   <= w_asm_next;
                    r_rdata <= r_we ? 32'd0 : w_ext;
                end
                ST_SPLIT: begin
                    r_asm <= w_asm_next;
                    r_k   <= r_k + 2'd1;
                    if (w_beat_last)
                        r_rdata <= r_we ? 32'd0 : w_ext;
                end
                default: r_k <= r_k;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Scoreboard bench for lsu_mem_master with a byte RAM model
// and a second SPLIT_EN=0 instance.
module tb_lsu_mem_master;
    import mem_pkg::*;

    typedef struct {
        logic        err;
        logic [31:0] rd;
        int          lat;
        int          t0;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  c;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_clr = 1'b1;

    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_size = 3'b000;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wData;
    logic [2:0]  ram_ramControl;
    logic [31:0] ram_rData;

    logic        req_valid2 = 1'b0;
    logic        req_ready2;
    logic        req_we2 = 1'b0;
    logic [2:0]  req_size2 = 3'b000;
    logic [31:0] req_addr2 = 32'd0;
    logic [31:0] req_wdata2 = 32'd0;
    logic        resp_valid2;
    logic        resp_err2;
    logic [31:0] resp_rdata2;
    logic        ram_we2;
    logic [31:0] ram_addr2;
    logic [31:0] ram_wData2;
    logic [2:0]  ram_ramControl2;
    logic [31:0] ram_rData2;

    logic [7:0]  mem [0:1023];
    logic [9:0]  ra;
    wr_t         wlog[$];
    exp_t        sb[$];
    int          cyc = 0;
    int          n_resp = 0;
    int          n_wr2 = 0;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    assign ram_rData2 = 32'd0;
    assign ra = ram_addr[9:0];

    lsu_mem_master #(.MEM_DEPTH(256), .SPLIT_EN(1'b1)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err),
        .resp_rdata(resp_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wData(ram_wData), .ram_ramControl(ram_ramControl),
        .ram_rData(ram_rData)
    );

    lsu_mem_master #(.MEM_DEPTH(256), .SPLIT_EN(1'b0)) dut2 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid2), .req_ready(req_ready2),
        .req_we(req_we2), .req_size(req_size2),
        .req_addr(req_addr2), .req_wdata(req_wdata2),
        .resp_valid(resp_valid2), .resp_err(resp_err2),
        .resp_rdata(resp_rdata2),
        .ram_we(ram_we2), .ram_addr(ram_addr2),
        .ram_wData(ram_wData2), .ram_ramControl(ram_ramControl2),
        .ram_rData(ram_rData2)
    );

    // RAM model read: raw right-aligned data, no extension
    always_comb begin
        ram_rData = 32'd0;
        case (ram_ramControl[1:0])
            2'b00: ram_rData = {mem[ra + 10'd3], mem[ra + 10'd2],
                                mem[ra + 10'd1], mem[ra]};
            2'b10: ram_rData = {16'd0, mem[ra + 10'd1], mem[ra]};
            default: ram_rData = {24'd0, mem[ra]};
        endcase
    end

    // RAM model write and write log
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
            for (int i = 8'h31; i <= 8'h34; i++) mem[i] = 8'hA5;
        end else if (ram_we) begin
            case (ram_ramControl[1:0])
                2'b00: begin
                    mem[ra]         = ram_wData[7:0];
                    mem[ra + 10'd1] = ram_wData[15:8];
                    mem[ra + 10'd2] = ram_wData[23:16];
                    mem[ra + 10'd3] = ram_wData[31:24];
                end
                2'b10: begin
                    mem[ra]         = ram_wData[7:0];
                    mem[ra + 10'd1] = ram_wData[15:8];
                end
                default: mem[ra] = ram_wData[7:0];
            endcase
            wlog.push_back('{ram_addr, ram_wData, ram_ramControl});
        end
        if (ram_we2) n_wr2 = n_wr2 + 1;
        cyc = cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Response monitor: pop expected entry on every resp_valid
    always @(negedge clk) begin
        exp_t e;
        if (!reset && resp_valid) begin
            n_resp = n_resp + 1;
            if (sb.size() == 0) begin
                check("spurious_resp", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("resp_err", {31'd0, resp_err}, {31'd0, e.err});
                check("resp_rdata", resp_rdata, e.rd);
                check("latency", 32'(cyc - e.t0), 32'(e.lat));
            end
        end
    end

    task automatic issue(input logic we, input logic [2:0] sz,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic eerr, input logic [31:0] erd,
                         input int elat);
        int w;
        int nb;
        w = 0;
        @(negedge clk);
        #1;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (!req_ready) begin
            check("ready_timeout", 32'd0, 32'd1);
            return;
        end
        nb = n_resp;
        sb.push_back('{eerr, erd, elat, cyc});
        req_valid = 1'b1;
        req_we    = we;
        req_size  = sz;
        req_addr  = a;
        req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        w = 0;
        while (n_resp == nb && w < 20) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (n_resp == nb) begin
            check("resp_timeout", 32'd0, 32'd1);
            sb.delete();
        end
    endtask

    initial begin
        int ws;
        int nr;
        #200000;
        $display("FAIL watchdog expired got=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int ws;
        int nr;
        repeat (2) @(posedge clk);
        @(negedge clk);
        mem_clr = 1'b0;
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_ram_we", {31'd0, ram_we}, 32'd0);
        check("rst_ram_addr", ram_addr, 32'd0);
        check("rst_ram_ctl", {29'd0, ram_ramControl}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        reset = 1'b0;

        // aligned word store then loads
        ws = wlog.size();
        issue(1'b1, SZ_W, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 2);
        check("st_w_beats", 32'(wlog.size() - ws), 32'd1);
        issue(1'b0, SZ_W, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 2);
        issue(1'b0, SZ_B, 32'h13, 32'h0, 1'b0, 32'hFFFFFFDE, 2);
        issue(1'b0, SZ_BU, 32'h13, 32'h0, 1'b0, 32'h000000DE, 2);

        // misaligned word store: four byte beats
        ws = wlog.size();
        issue(1'b1, SZ_W, 32'h21, 32'h11223344, 1'b0, 32'h0, 5);
        check("split_st_beats", 32'(wlog.size() - ws), 32'd4);
        if (wlog.size() - ws == 4) begin
            for (int k = 0; k < 4; k++) begin
                check("split_st_addr", wlog[ws + k].a, 32'h21 + 32'(k));
                check("split_st_ctl", {29'd0, wlog[ws + k].c}, 32'd1);
            end
            check("split_st_d0", wlog[ws].d, 32'h44);
            check("split_st_d1", wlog[ws + 1].d, 32'h33);
            check("split_st_d2", wlog[ws + 2].d, 32'h22);
            check("split_st_d3", wlog[ws + 3].d, 32'h11);
        end
        issue(1'b0, SZ_W, 32'h21, 32'h0, 1'b0, 32'h11223344, 5);

        // misaligned half store/loads
        ws = wlog.size();
        issue(1'b1, SZ_H, 32'h23, 32'h00009080, 1'b0, 32'h0, 3);
        check("split_h_beats", 32'(wlog.size() - ws), 32'd2);
        issue(1'b0, SZ_H, 32'h23, 32'h0, 1'b0, 32'hFFFF9080, 3);
        issue(1'b0, SZ_HU, 32'h23, 32'h0, 1'b0, 32'h00009080, 3);

        // range boundary and error cases
        issue(1'b0, SZ_W, 32'h3FC, 32'h0, 1'b0, 32'h0, 2);
        ws = wlog.size();
        issue(1'b0, 3'b011, 32'h40, 32'h0, 1'b1, 32'h0, 1);
        issue(1'b1, SZ_BU, 32'h40, 32'h55, 1'b1, 32'h0, 1);
        issue(1'b1, SZ_HU, 32'h40, 32'h55, 1'b1, 32'h0, 1);
        issue(1'b0, SZ_W, 32'h3FE, 32'h0, 1'b1, 32'h0, 1);
        issue(1'b1, SZ_W, 32'h3FE, 32'h1, 1'b1, 32'h0, 1);
        issue(1'b0, SZ_H, 32'hFFFFFFFF, 32'h0, 1'b1, 32'h0, 1);
        check("err_no_beats", 32'(wlog.size() - ws), 32'd0);

        // reset during beat 1 of a split word store
        @(negedge clk);
        #1;
        ws = wlog.size();
        nr = n_resp;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = SZ_W;
        req_addr  = 32'h31;
        req_wdata = 32'hCAFEBABE;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("beat1_we", {31'd0, ram_we}, 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_we", {31'd0, ram_we}, 32'd0);
        check("mid_rst_addr", ram_addr, 32'd0);
        check("mid_rst_wdata", ram_wData, 32'd0);
        check("mid_rst_ctl", {29'd0, ram_ramControl}, 32'd0);
        check("mid_rst_ready", {31'd0, req_ready}, 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_rst_beats", 32'(wlog.size() - ws), 32'd1);
        check("mid_rst_resp", 32'(n_resp - nr), 32'd0);
        check("mem31", {24'd0, mem[32'h31]}, 32'hBE);
        check("mem32", {24'd0, mem[32'h32]}, 32'hA5);
        check("mem33", {24'd0, mem[32'h33]}, 32'hA5);
        check("mem34", {24'd0, mem[32'h34]}, 32'hA5);
        issue(1'b0, SZ_W, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 2);

        // SPLIT_EN=0 instance
        @(negedge clk);
        req_valid2 = 1'b1;
        req_we2    = 1'b0;
        req_size2  = SZ_W;
        req_addr2  = 32'h2;
        @(posedge clk);
        #1;
        req_valid2 = 1'b0;
        @(negedge clk);
        check("nosplit_valid", {31'd0, resp_valid2}, 32'd1);
        check("nosplit_err", {31'd0, resp_err2}, 32'd1);
        check("nosplit_rdata", resp_rdata2, 32'd0);
        @(negedge clk);
        check("nosplit_ready", {31'd0, req_ready2}, 32'd1);
        req_valid2 = 1'b1;
        req_size2  = SZ_HU;
        req_addr2  = 32'h2;
        @(posedge clk);
        #1;
        req_valid2 = 1'b0;
        @(negedge clk);
        check("ns_single_valid", {31'd0, resp_valid2}, 32'd0);
        check("ns_single_addr", ram_addr2, 32'h2);
        check("ns_single_ctl", {29'd0, ram_ramControl2}, 32'(SZ_HU));
        check("ns_single_wdata", ram_wData2, 32'd0);
        @(negedge clk);
        check("ns_al_valid", {31'd0, resp_valid2}, 32'd1);
        check("ns_al_err", {31'd0, resp_err2}, 32'd0);
        check("nosplit_wr", 32'(n_wr2), 32'd0);

        repeat (2) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
